// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg : shared types and helpers for the key-matrix scanner
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  typedef enum logic [0:0] {
    DRIVE = 1'b0,
    EVAL  = 1'b1
  } scan_state_e;

  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_MANY = 2'd2
  } pop_class_e;

  // Widest supported matrix is 8 x 8.
  localparam int MAX_KEYS = 64;

  function automatic int code_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  function automatic pop_class_e pop_class(input logic [MAX_KEYS-1:0] map);
    int n;
    n = 0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      n += int'(map[i]);
    end
    if (n == 0)      return POP_NONE;
    else if (n == 1) return POP_ONE;
    else             return POP_MANY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan_if.sv
// ============================================================================
// keypad_scan_if : matrix pins and key-event bus of the keypad scanner
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_scan_if
  import keypad_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
);

  localparam int CW = code_width(ROWS, COLS);

  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;
  logic            key_multi;

  modport master (
    output row_n,
    output key_code,
    output key_valid,
    output key_held,
    output key_multi,
    input  col_n
  );

  modport slave (
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  key_multi,
    output col_n
  );

endinterface

`default_nettype wire

// File: rtl/keypad_frame_deb.sv
// ============================================================================
// keypad_frame_deb : whole-frame debouncer holding raw/previous/accepted maps
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_frame_deb #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DEB_SCANS = 20
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     i_store,
  input  wire logic [$clog2(ROWS)-1:0]  i_row,
  input  wire logic [COLS-1:0]          i_bits,
  input  wire logic                     i_eval,
  output logic      [ROWS*COLS-1:0]     o_acc_q,
  output logic      [ROWS*COLS-1:0]     o_acc_d,
  output logic                          o_update
);

  localparam int N  = ROWS * COLS;
  localparam int SW = $clog2(DEB_SCANS);
  localparam logic [SW-1:0] C_STABLE_MAX = SW'(DEB_SCANS - 1);

  logic [N-1:0]  raw_q, raw_d;
  logic [N-1:0]  prev_q, prev_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          update;

  always_comb begin
    raw_d    = raw_q;
    prev_d   = prev_q;
    acc_d    = acc_q;
    stable_d = stable_q;
    update   = 1'b0;

    if (i_store) begin
      raw_d[int'(i_row)*COLS +: COLS] = i_bits;
    end

    if (i_eval) begin
      // Any frame that differs from its predecessor restarts the count.
      if (raw_q == prev_q) begin
        stable_d = (stable_q == C_STABLE_MAX) ? C_STABLE_MAX : stable_q + 1'b1;
      end else begin
        stable_d = '0;
      end
      prev_d = raw_q;
      if ((stable_d == C_STABLE_MAX) && (raw_q != acc_q)) begin
        update = 1'b1;
        acc_d  = raw_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q    <= '0;
      prev_q   <= '0;
      acc_q    <= '0;
      stable_q <= '0;
    end else begin
      raw_q    <= raw_d;
      prev_q   <= prev_d;
      acc_q    <= acc_d;
      stable_q <= stable_d;
    end
  end

  assign o_acc_q  = acc_q;
  assign o_acc_d  = acc_d;
  assign o_update = update;

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// keypad_scan : row-drive / column-sense matrix scanner with frame debounce
//               and one-cycle key-code strobe. KEYPAD_REPEAT_EN adds repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 24000,
  parameter int DEB_SCANS    = 20,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 6
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  keypad_scan_if.master  bus
);

  localparam int N  = ROWS * COLS;
  localparam int CW = code_width(ROWS, COLS);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);

  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < 4 ||
      DEB_SCANS < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scan: parameter out of range");
  end

  scan_state_e   state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [ROWS-1:0] row_n_q, row_n_d;
  logic [COLS-1:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [CW-1:0] key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          key_multi_q, key_multi_d;

  logic          store_en, eval_en, update, rpt_fire;
  logic [N-1:0]  acc_q, acc_d, new_bits;
  logic [CW-1:0] press_idx;
  pop_class_e    acc_class;

  keypad_frame_deb #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .DEB_SCANS (DEB_SCANS)
  ) u_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_store  (store_en),
    .i_row    (row_q),
    .i_bits   (~col_s2_q),
    .i_eval   (eval_en),
    .o_acc_q  (acc_q),
    .o_acc_d  (acc_d),
    .o_update (update)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    dwell_d  = dwell_q;
    store_en = 1'b0;
    eval_en  = 1'b0;
    col_s1_d = bus.col_n;
    col_s2_d = col_s1_q;

    case (state_q)
      DRIVE: begin
        if (dwell_q == DW'(SCAN_DIV - 1)) begin
          store_en = 1'b1;
          dwell_d  = '0;
          if (row_q == RW'(ROWS - 1)) begin
            state_d = EVAL;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      EVAL: begin
        eval_en = 1'b1;
        row_d   = '0;
        state_d = DRIVE;
      end
      default: state_d = DRIVE;
    endcase

    // Row drive is registered from the next state, so it lines up with the dwell.
    row_n_d = (state_d == DRIVE) ? ~(ROWS'(1) << row_d) : '1;
  end

  always_comb begin
    press_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (acc_d[i]) press_idx = CW'(i);
    end
  end

  always_comb begin
    acc_class   = pop_class(64'(acc_d));
    new_bits    = acc_d & ~acc_q;
    key_held_d  = (acc_class == POP_ONE);
    key_multi_d = (acc_class == POP_MANY);
    key_valid_d = rpt_fire;
    key_code_d  = key_code_q;
    // Only a fresh single press strobes; release and multi->single stay silent.
    if (update && (acc_class == POP_ONE) && (|new_bits)) begin
      key_valid_d = 1'b1;
      key_code_d  = press_idx;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int PW      = $clog2(RPT_MAX + 1);

  logic [PW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_nxt;
  logic          rpt_arm_q, rpt_arm_d;

  // First repeat after REPEAT_DELAY frames, then every REPEAT_RATE frames.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_arm_d = rpt_arm_q;
    rpt_fire  = 1'b0;
    rpt_nxt   = rpt_cnt_q + 1'b1;
    if (update || !key_held_q) begin
      rpt_cnt_d = '0;
      rpt_arm_d = 1'b0;
    end else if (eval_en) begin
      if (!rpt_arm_q && (rpt_nxt == PW'(REPEAT_DELAY))) begin
        rpt_fire  = 1'b1;
        rpt_arm_d = 1'b1;
        rpt_cnt_d = '0;
      end else if (rpt_arm_q && (rpt_nxt == PW'(REPEAT_RATE))) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q <= '0;
      rpt_arm_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_arm_q <= rpt_arm_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DRIVE;
      row_q       <= '0;
      dwell_q     <= '0;
      row_n_q     <= '1;
      col_s1_q    <= '1;
      col_s2_q    <= '1;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      key_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      row_n_q     <= row_n_d;
      col_s1_q    <= col_s1_d;
      col_s2_q    <= col_s2_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      key_multi_q <= key_multi_d;
    end
  end

  assign bus.row_n     = row_n_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;
  assign bus.key_multi = key_multi_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
// tb_keypad_scan : directed + random key-matrix stimulus against a frame model
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scan;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NK   = ROWS * COLS;
  localparam int DEB  = 3;
  localparam int RD   = 4;
  localparam int RR   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic [NK-1:0]   keys = '0;
  logic [COLS-1:0] col_w;

  always #5 clk = ~clk;

  keypad_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  keypad_scan #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .SCAN_DIV     (4),
    .DEB_SCANS    (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Passive matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col_w = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !bus.row_n[r]) col_w[c] = 1'b0;
  end
  assign bus.col_n = col_w;

  int total = 0;
  int bad   = 0;
  int unk   = 0;
  int bcnt  = 0;

  // Frame-level reference: accept a map once the last DEB snapshots agree.
  int hist[$];
  int acc_m;
  int code_m;
  int age_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(0);
    acc_m  = 0;
    code_m = 0;
    age_m  = 0;
  endtask

  task automatic model_frame(input int snap, output bit ev);
    bit stable;
    bit upd;
    int nb;
    logic [NK-1:0] s16;
    logic [NK-1:0] a16;
`ifdef KEYPAD_REPEAT_EN
    bit held_before;
    a16 = acc_m[NK-1:0];
    held_before = ($countones(a16) == 1);
`endif
    ev = 1'b0;
    hist.push_back(snap);
    if (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != snap) stable = 1'b0;
    upd = stable && (snap >= 0) && (snap != acc_m);
    if (upd) begin
      nb  = snap & ~acc_m;
      s16 = snap[NK-1:0];
      if (($countones(s16) == 1) && (nb != 0)) begin
        ev = 1'b1;
        for (int i = 0; i < NK; i++) if (s16[i]) code_m = i;
      end
      acc_m = snap;
      age_m = 0;
    end
`ifdef KEYPAD_REPEAT_EN
    else if (!held_before) begin
      age_m = 0;
    end else begin
      age_m++;
      if ((age_m == RD) || ((age_m > RD) && ((age_m - RD) % RR == 0))) ev = 1'b1;
    end
`endif
  endtask

  task automatic run_frame(input logic [NK-1:0] k, input bit bounce, input int ncyc,
                           input string tag);
    int stray;
    int snap;
    bit ev;
    logic [NK-1:0] a16;
    stray = 0;
    if (!bounce) keys = k;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (bounce) begin
        bcnt++;
        if (bcnt % 5 == 0) keys = keys ^ k;
      end
      if ((i < ncyc - 1) && (bus.key_valid !== 1'b0)) stray++;
    end
    check({tag, "/stray"}, stray, 0);
    if (bounce) begin
      unk++;
      snap = -unk;
    end else begin
      snap = int'(k);
    end
    model_frame(snap, ev);
    a16 = acc_m[NK-1:0];
    check({tag, "/valid"}, 32'(bus.key_valid), 32'(ev));
    check({tag, "/code"},  32'(bus.key_code),  code_m);
    check({tag, "/held"},  32'(bus.key_held),  32'($countones(a16) == 1));
    check({tag, "/multi"}, 32'(bus.key_multi), 32'($countones(a16) >= 2));
  endtask

  task automatic hold(input logic [NK-1:0] k, input int frames, input string tag);
    for (int f = 0; f < frames; f++) run_frame(k, 1'b0, 17, tag);
  endtask

  task automatic release_reset(input logic [NK-1:0] k, input string tag);
    keys  = k;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "/row_first"}, 32'(bus.row_n), 32'(4'b1110));
    model_reset();
    run_frame(k, 1'b0, 16, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/row_n"}, 32'(bus.row_n),     32'(4'b1111));
    check({tag, "/valid"}, 32'(bus.key_valid), 0);
    check({tag, "/held"},  32'(bus.key_held),  0);
    check({tag, "/multi"}, 32'(bus.key_multi), 0);
    check({tag, "/code"},  32'(bus.key_code),  0);
  endtask

  initial begin
    logic [NK-1:0] k;
    int len;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    release_reset('0, "por");
    hold('0, 1, "idle");

    hold(NK'(1) << 9, 4, "press9");
    hold('0, 4, "release9");

    // Contact chatter on key 9 for two frames, then a clean hold.
    keys = NK'(1) << 9;
    bcnt = 0;
    run_frame(NK'(1) << 9, 1'b1, 17, "bounce");
    run_frame(NK'(1) << 9, 1'b1, 17, "bounce");
    hold(NK'(1) << 9, 4, "settle9");
    hold('0, 4, "release9b");

    hold((NK'(1) << 0) | (NK'(1) << 15), 4, "multi");
    hold(NK'(1) << 0, 4, "multi2one");
    hold('0, 4, "release0");

    // Reset mid-frame while a key is accepted.
    hold(NK'(1) << 9, 4, "prereset");
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    release_reset(NK'(1) << 9, "midrst");
    hold(NK'(1) << 9, 3, "heldatrst");
    hold('0, 4, "release_rst");

    hold(NK'(1) << 5, 14, "long5");
    hold('0, 4, "release5");

    for (int seg = 0; seg < 30; seg++) begin
      k = '0;
      case ($urandom_range(0, 3))
        0: k = '0;
        1, 2: k[$urandom_range(0, NK - 1)] = 1'b1;
        default: begin
          k[$urandom_range(0, NK - 1)] = 1'b1;
          k[$urandom_range(0, NK - 1)] = 1'b1;
        end
      endcase
      len = $urandom_range(1, 5);
      hold(k, len, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
